// File: rtl/mem_access_unit_if.sv
// ----------------------------------------------------------------------------
// mem_access_unit_if
// Purpose : bundles the CPU request/response channel and the 64-bit data
//           memory channel of mem_access_unit into one interface.
// Signals : req_*  - CPU access request (valid/ready handshake)
//           resp_* - one-cycle response pulse with load data / error flag
//           mem_*  - doubleword-wide memory strobes, address and data
// Modports: slave  - the access unit's view
//           master - the requester/memory side (CPU + memory model)
// ----------------------------------------------------------------------------
interface mem_access_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic        mem_read;
   logic        mem_write;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;

   modport slave (
      input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready,
      output resp_valid, resp_rdata, resp_err,
      output mem_read, mem_write, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready,
      input  resp_valid, resp_rdata, resp_err,
      input  mem_read, mem_write, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit
// Purpose : converts byte/half/word/doubleword CPU loads and stores into
//           accesses on a 64-bit data memory. Loads extract and extend one
//           little-endian lane; partial stores do a read-modify-write;
//           misaligned requests are answered with an error and never touch
//           memory.
// Ports   : clk     - rising-edge clock shared with the data memory
//           reset_n - synchronous active-low reset
//           bus     - mem_access_unit_if.slave (request, response, memory)
// ----------------------------------------------------------------------------
module mem_access_unit (
   input logic              clk,
   input logic              reset_n,
   mem_access_unit_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RD     = 3'd1,
      S_RMW_RD = 3'd2,
      S_WR     = 3'd3,
      S_RESP   = 3'd4
   } state_t;

   state_t      state_q;
   logic [1:0]  size_q;
   logic        uns_q;
   logic [63:0] addr_q;
   logic [63:0] wdata_q;
   logic        req_ready_q;
   logic        mem_read_q;
   logic        mem_write_q;
   logic [63:0] mem_addr_q;
   logic [63:0] mem_wdata_q;
   logic        resp_valid_q;
   logic [63:0] resp_rdata_q;
   logic        resp_err_q;

   // Byte is always aligned; larger sizes need their low address bits clear.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] a);
      is_misaligned = 1'b0;
      case (size)
         2'd1:    is_misaligned = a[0];
         2'd2:    is_misaligned = |a[1:0];
         2'd3:    is_misaligned = |a[2:0];
         default: is_misaligned = 1'b0;
      endcase
   endfunction

   // Mask of the low bytes covered by an access of the given size.
   function automatic logic [63:0] size_mask(input logic [1:0] size);
      size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
      case (size)
         2'd0:    size_mask = 64'h0000_0000_0000_00FF;
         2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
         2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
         default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
   endfunction

   // Right-justify the lane starting at byte 'off', then sign/zero extend.
   function automatic logic [63:0] extract_lane(input logic [63:0] dw, input logic [2:0] off,
                                                input logic [1:0] size, input logic uns);
      logic [63:0] s;
      s = dw >> {off, 3'b000};
      extract_lane = s;
      case (size)
         2'd0:    extract_lane = uns ? {56'd0, s[7:0]}  : {{56{s[7]}},  s[7:0]};
         2'd1:    extract_lane = uns ? {48'd0, s[15:0]} : {{48{s[15]}}, s[15:0]};
         2'd2:    extract_lane = uns ? {32'd0, s[31:0]} : {{32{s[31]}}, s[31:0]};
         default: extract_lane = s;
      endcase
   endfunction

   // Replace the store lane(s) of the read doubleword with the store data.
   function automatic logic [63:0] merge_lane(input logic [63:0] dw, input logic [63:0] wd,
                                              input logic [2:0] off, input logic [1:0] size);
      logic [63:0] m;
      m = size_mask(size);
      merge_lane = (dw & ~(m << {off, 3'b000})) | ((wd & m) << {off, 3'b000});
   endfunction

   // Access FSM; every output is registered alongside the state.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         size_q       <= 2'd0;
         uns_q        <= 1'b0;
         addr_q       <= 64'd0;
         wdata_q      <= 64'd0;
         req_ready_q  <= 1'b1;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= 64'd0;
         mem_wdata_q  <= 64'd0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 64'd0;
         resp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.req_valid) begin
                  size_q      <= bus.req_size;
                  uns_q       <= bus.req_unsigned;
                  addr_q      <= bus.req_addr;
                  wdata_q     <= bus.req_wdata;
                  req_ready_q <= 1'b0;
                  if (is_misaligned(bus.req_size, bus.req_addr[2:0])) begin
                     state_q      <= S_RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_rdata_q <= 64'd0;
                  end else if (!bus.req_write) begin
                     state_q    <= S_RD;
                     mem_read_q <= 1'b1;
                     mem_addr_q <= {bus.req_addr[63:3], 3'b000};
                  end else if (bus.req_size == 2'd3) begin
                     // Full doubleword needs no read-back.
                     state_q     <= S_WR;
                     mem_write_q <= 1'b1;
                     mem_addr_q  <= {bus.req_addr[63:3], 3'b000};
                     mem_wdata_q <= bus.req_wdata;
                  end else begin
                     state_q    <= S_RMW_RD;
                     mem_read_q <= 1'b1;
                     mem_addr_q <= {bus.req_addr[63:3], 3'b000};
                  end
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_RD: begin
               state_q      <= S_RESP;
               mem_read_q   <= 1'b0;
               mem_addr_q   <= 64'd0;
               resp_valid_q <= 1'b1;
               resp_rdata_q <= extract_lane(bus.mem_rdata, addr_q[2:0], size_q, uns_q);
            end
            S_RMW_RD: begin
               // Address stays put: the write targets the same doubleword.
               state_q     <= S_WR;
               mem_read_q  <= 1'b0;
               mem_write_q <= 1'b1;
               mem_wdata_q <= merge_lane(bus.mem_rdata, wdata_q, addr_q[2:0], size_q);
            end
            S_WR: begin
               state_q      <= S_RESP;
               mem_write_q  <= 1'b0;
               mem_addr_q   <= 64'd0;
               mem_wdata_q  <= 64'd0;
               resp_valid_q <= 1'b1;
               resp_rdata_q <= 64'd0;
            end
            S_RESP: begin
               state_q      <= S_IDLE;
               resp_valid_q <= 1'b0;
               resp_rdata_q <= 64'd0;
               resp_err_q   <= 1'b0;
               req_ready_q  <= 1'b1;
            end
            default: begin
               state_q      <= S_IDLE;
               req_ready_q  <= 1'b1;
               mem_read_q   <= 1'b0;
               mem_write_q  <= 1'b0;
               mem_addr_q   <= 64'd0;
               mem_wdata_q  <= 64'd0;
               resp_valid_q <= 1'b0;
               resp_rdata_q <= 64'd0;
               resp_err_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_err   = resp_err_q;
   // Strobes gated by reset_n so a store caught by reset never commits.
   assign bus.mem_read   = mem_read_q & reset_n;
   assign bus.mem_write  = mem_write_q & reset_n;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// ----------------------------------------------------------------------------
// tb_mem_access_unit
// Purpose : directed self-checking bench for mem_access_unit with a small
//           64-bit memory model (8 doublewords, indexed by mem_addr[5:3]).
// ----------------------------------------------------------------------------
module tb_mem_access_unit;

   logic clk;
   logic reset_n;
   int   n_cmp;
   int   n_err;
   logic [63:0] mem [0:7];

   mem_access_unit_if bus ();

   mem_access_unit dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: combinational read while mem_read, commit on rising clk.
   assign bus.mem_rdata = bus.mem_read ? mem[bus.mem_addr[5:3]] : 64'd0;
   always @(posedge clk) begin
      if (bus.mem_write) mem[bus.mem_addr[5:3]] <= bus.mem_wdata;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".ready"},  64'(bus.req_ready),  64'd1);
      check({tag, ".rvalid"}, 64'(bus.resp_valid), 64'd0);
      check({tag, ".rdata"},  bus.resp_rdata,      64'd0);
      check({tag, ".err"},    64'(bus.resp_err),   64'd0);
      check({tag, ".mrd"},    64'(bus.mem_read),   64'd0);
      check({tag, ".mwr"},    64'(bus.mem_write),  64'd0);
      check({tag, ".maddr"},  bus.mem_addr,        64'd0);
      check({tag, ".mwdata"}, bus.mem_wdata,       64'd0);
   endtask

   // Present a request and pass the acceptance edge, then withdraw it.
   task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wd);
      bus.req_valid    = 1'b1;
      bus.req_write    = wr;
      bus.req_size     = sz;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wd;
      tick();
      bus.req_valid    = 1'b0;
   endtask

   task automatic run_load(input string tag, input logic [1:0] sz, input logic uns,
                           input logic [63:0] addr, input logic [63:0] exp);
      issue(1'b0, sz, uns, addr, 64'd0);
      check({tag, ".rd_mrd"},   64'(bus.mem_read),   64'd1);
      check({tag, ".rd_maddr"}, bus.mem_addr,        {addr[63:3], 3'b000});
      check({tag, ".rd_ready"}, 64'(bus.req_ready),  64'd0);
      check({tag, ".rd_rv"},    64'(bus.resp_valid), 64'd0);
      tick();
      check({tag, ".resp_v"},   64'(bus.resp_valid), 64'd1);
      check({tag, ".resp_d"},   bus.resp_rdata,      exp);
      check({tag, ".resp_e"},   64'(bus.resp_err),   64'd0);
      check({tag, ".resp_mrd"}, 64'(bus.mem_read),   64'd0);
      tick();
      check_idle({tag, ".idle"});
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      for (int i = 0; i < 8; i++) mem[i] = 64'd0;
      mem[1] = 64'hF0E1_D2C3_B4A5_9687;
      reset_n          = 1'b0;
      bus.req_valid    = 1'b0;
      bus.req_write    = 1'b0;
      bus.req_size     = 2'd0;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 64'd0;
      bus.req_wdata    = 64'd0;
      tick();
      tick();
      check_idle("reset");
      reset_n = 1'b1;
      tick();
      check_idle("post_reset");

      // Loads from doubleword @0x08.
      run_load("ld_b0f_s",  2'd0, 1'b0, 64'h0F, 64'hFFFF_FFFF_FFFF_FFF0);
      run_load("ld_b0f_u",  2'd0, 1'b1, 64'h0F, 64'h0000_0000_0000_00F0);
      run_load("ld_h0c_s",  2'd1, 1'b0, 64'h0C, 64'hFFFF_FFFF_FFFF_D2C3);
      run_load("ld_w08_u",  2'd2, 1'b1, 64'h08, 64'h0000_0000_B4A5_9687);
      run_load("ld_d08",    2'd3, 1'b0, 64'h08, 64'hF0E1_D2C3_B4A5_9687);

      // Byte store AA @0x09: RMW_RD, WR, RESP.
      issue(1'b1, 2'd0, 1'b0, 64'h09, 64'h0000_0000_0000_00AA);
      check("sb.rmw_mrd",   64'(bus.mem_read),  64'd1);
      check("sb.rmw_mwr",   64'(bus.mem_write), 64'd0);
      check("sb.rmw_maddr", bus.mem_addr,       64'h08);
      tick();
      check("sb.wr_mwr",    64'(bus.mem_write), 64'd1);
      check("sb.wr_mrd",    64'(bus.mem_read),  64'd0);
      check("sb.wr_maddr",  bus.mem_addr,       64'h08);
      check("sb.wr_wdata",  bus.mem_wdata,      64'hF0E1_D2C3_B4A5_AA87);
      tick();
      check("sb.resp_v",    64'(bus.resp_valid), 64'd1);
      check("sb.resp_d",    bus.resp_rdata,      64'd0);
      check("sb.resp_mwr",  64'(bus.mem_write),  64'd0);
      check("sb.mem",       mem[1],              64'hF0E1_D2C3_B4A5_AA87);
      tick();
      check_idle("sb.idle");

      // Doubleword store @0x10: no read, write right away, resp at N+2.
      issue(1'b1, 2'd3, 1'b0, 64'h10, 64'h1122_3344_5566_7788);
      check("sd.wr_mrd",   64'(bus.mem_read),  64'd0);
      check("sd.wr_mwr",   64'(bus.mem_write), 64'd1);
      check("sd.wr_maddr", bus.mem_addr,       64'h10);
      check("sd.wr_wdata", bus.mem_wdata,      64'h1122_3344_5566_7788);
      tick();
      check("sd.resp_v",   64'(bus.resp_valid), 64'd1);
      check("sd.resp_d",   bus.resp_rdata,      64'd0);
      tick();
      check_idle("sd.idle");
      run_load("ld_d10", 2'd3, 1'b0, 64'h10, 64'h1122_3344_5566_7788);

      // Word store at upper half, then read back signed and as a half.
      issue(1'b1, 2'd2, 1'b0, 64'h0C, 64'h0000_0000_DEAD_BEEF);
      tick();
      check("sw.wr_wdata", bus.mem_wdata, 64'hDEAD_BEEF_B4A5_AA87);
      tick();
      tick();
      run_load("ld_w0c_s", 2'd2, 1'b0, 64'h0C, 64'hFFFF_FFFF_DEAD_BEEF);
      run_load("ld_h0e_u", 2'd1, 1'b1, 64'h0E, 64'h0000_0000_0000_DEAD);

      // Misaligned word load @0x0A.
      issue(1'b0, 2'd2, 1'b0, 64'h0A, 64'd0);
      check("mis.resp_v", 64'(bus.resp_valid), 64'd1);
      check("mis.err",    64'(bus.resp_err),   64'd1);
      check("mis.rdata",  bus.resp_rdata,      64'd0);
      check("mis.mrd",    64'(bus.mem_read),   64'd0);
      check("mis.mwr",    64'(bus.mem_write),  64'd0);
      tick();
      check_idle("mis.idle");

      // Misaligned half store @0x11 must not touch memory.
      issue(1'b1, 2'd1, 1'b0, 64'h11, 64'h0000_0000_0000_1234);
      check("mis2.err", 64'(bus.resp_err),  64'd1);
      check("mis2.mwr", 64'(bus.mem_write), 64'd0);
      tick();
      check("mis2.mem", mem[2], 64'h1122_3344_5566_7788);

      // req_valid held high: second request waits until after RESP.
      bus.req_valid    = 1'b1;
      bus.req_write    = 1'b0;
      bus.req_size     = 2'd0;
      bus.req_unsigned = 1'b1;
      bus.req_addr     = 64'h08;
      tick();
      check("b2b.rd_ready",   64'(bus.req_ready),  64'd0);
      check("b2b.rd_mrd",     64'(bus.mem_read),   64'd1);
      tick();
      check("b2b.resp_ready", 64'(bus.req_ready),  64'd0);
      check("b2b.resp_d",     bus.resp_rdata,      64'h87);
      tick();
      check("b2b.idle_ready", 64'(bus.req_ready),  64'd1);
      check("b2b.idle_mrd",   64'(bus.mem_read),   64'd0);
      check("b2b.idle_rv",    64'(bus.resp_valid), 64'd0);
      tick();
      bus.req_valid = 1'b0;
      check("b2b.rd2_mrd",    64'(bus.mem_read),   64'd1);
      check("b2b.rd2_ready",  64'(bus.req_ready),  64'd0);
      tick();
      check("b2b.resp2_v",    64'(bus.resp_valid), 64'd1);
      tick();
      check_idle("b2b.idle2");

      // Reset during WR of a byte store to 0x08.
      issue(1'b1, 2'd0, 1'b0, 64'h08, 64'h0000_0000_0000_0055);
      tick();
      check("rst.wr_mwr", 64'(bus.mem_write), 64'd1);
      reset_n = 1'b0;
      #1;
      check("rst.gated_mwr", 64'(bus.mem_write), 64'd0);
      tick();
      check_idle("rst.idle");
      check("rst.mem", mem[1], 64'hDEAD_BEEF_B4A5_AA87);
      reset_n = 1'b1;
      tick();
      check_idle("rst.after");
      run_load("ld_after_rst", 2'd0, 1'b1, 64'h08, 64'h0000_0000_0000_0087);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
